// File: rtl/clock_alarm_rtc_pkg.sv
// clock_alarm_pkg: register addresses, bit indices, BCD limits and BCD helpers for clock_alarm_rtc
package clock_alarm_pkg;
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_TIME_HM  = 3'd2;
  localparam logic [2:0] ADDR_TIME_S   = 3'd3;
  localparam logic [2:0] ADDR_ALARM_HM = 3'd4;
  localparam int CTRL_RUN          = 0;
  localparam int CTRL_ALARM_EN     = 1;
  localparam int CTRL_SEC_IRQ_EN   = 2;
  localparam int CTRL_ALARM_IRQ_EN = 3;
  localparam int ST_SEC   = 0;
  localparam int ST_ALARM = 1;
  localparam int ST_ERR   = 2;
  localparam logic [7:0] BCD_MAX_MS = 8'h59;
  localparam logic [7:0] BCD_MAX_HR = 8'h23;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    return v == max ? 8'h00 : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'h0} : v + 8'd1;
  endfunction
  function automatic logic bcd_ok(input logic [7:0] v, input logic [7:0] max);
    return v[3:0] <= 4'd9 && v[7:4] <= 4'd9 && v <= max;
  endfunction
endpackage

// File: rtl/clock_alarm_rtc_if.sv
// clock_alarm_rtc_if: 16-bit Avalon-MM slave bus (address, chipselect, write_n, writedata, readdata)
interface clock_alarm_rtc_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  modport master(output address, chipselect, write_n, writedata, input readdata);
  modport slave(input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/clock_alarm_rtc_bcd_mod_counter.sv
// bcd_mod_counter: 2-digit BCD counter 00..MAX_BCD (clk, rst, inc, load, load_value -> value, carry)
module bcd_mod_counter
  import clock_alarm_pkg::*;
#(
  parameter logic [7:0] MAX_BCD = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_value,
  output logic [7:0] value,
  output logic       carry
);
  assign carry = inc && value == MAX_BCD;
  always_ff @(posedge clk)
    if (rst) value <= 8'h00;
    else if (load) value <= load_value;
    else if (inc) value <= bcd_inc(value, MAX_BCD);
endmodule

// File: rtl/clock_alarm_rtc.sv
// clock_alarm_rtc: BCD time-of-day + alarm engine (clk, reset, tick, bus slave -> irq, alarm_out)
module clock_alarm_rtc
  import clock_alarm_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  clock_alarm_rtc_if.slave    bus,
  output logic                irq,
  output logic                alarm_out
);
  localparam logic [19:0] PRE_MAX = 20'(TICKS_PER_SEC - 1);
  logic [19:0] presc;
  logic [3:0]  ctrl;
  logic [2:0]  status, st_set, st_clr;
  logic [7:0]  ss, mm, hh, nxt_m, nxt_h;
  logic [15:0] alarm_hm, wd, rd;
  logic wr, hm_ok, s_ok, ld_hm, ld_s, ld_al, err_set, time_wr, sec_adv;
  logic s_carry, m_carry, h_carry, match;
  assign wd      = bus.writedata;
  assign wr      = bus.chipselect && !bus.write_n;
  assign hm_ok   = bcd_ok(wd[15:8], BCD_MAX_HR) && bcd_ok(wd[7:0], BCD_MAX_MS);
  assign s_ok    = bcd_ok(wd[7:0], BCD_MAX_MS);
  assign ld_hm   = wr && bus.address == ADDR_TIME_HM && hm_ok;
  assign ld_s    = wr && bus.address == ADDR_TIME_S && s_ok;
  assign ld_al   = wr && bus.address == ADDR_ALARM_HM && hm_ok;
  assign err_set = wr && ((bus.address == ADDR_TIME_HM || bus.address == ADDR_ALARM_HM) && !hm_ok
                          || bus.address == ADDR_TIME_S && !s_ok);
  assign time_wr = ld_hm || ld_s;
  // a valid time write restarts the second, so it also swallows a coincident advance
  assign sec_adv = ctrl[CTRL_RUN] && tick && presc == PRE_MAX && !time_wr;
  bcd_mod_counter #(.MAX_BCD(BCD_MAX_MS)) u_sec (
    .clk(clk), .rst(reset), .inc(sec_adv), .load(time_wr),
    .load_value(ld_hm ? 8'h00 : wd[7:0]), .value(ss), .carry(s_carry)
  );
  bcd_mod_counter #(.MAX_BCD(BCD_MAX_MS)) u_min (
    .clk(clk), .rst(reset), .inc(s_carry), .load(ld_hm),
    .load_value(wd[7:0]), .value(mm), .carry(m_carry)
  );
  bcd_mod_counter #(.MAX_BCD(BCD_MAX_HR)) u_hr (
    .clk(clk), .rst(reset), .inc(m_carry), .load(ld_hm),
    .load_value(wd[15:8]), .value(hh), .carry(h_carry)
  );
  // the alarm compares against the time being written on this edge, seconds rolling to 00
  assign nxt_m = m_carry ? 8'h00 : s_carry ? bcd_inc(mm, BCD_MAX_MS) : mm;
  assign nxt_h = h_carry ? 8'h00 : m_carry ? bcd_inc(hh, BCD_MAX_HR) : hh;
  assign match = sec_adv && s_carry && {nxt_h, nxt_m} == alarm_hm && ctrl[CTRL_ALARM_EN];
  always_comb begin
    st_set = '0;
    st_set[ST_SEC]   = sec_adv;
    st_set[ST_ALARM] = match;
    st_set[ST_ERR]   = err_set;
  end
  assign st_clr = wr && bus.address == ADDR_STATUS ? wd[2:0] : 3'b000;
  assign rd = bus.address == ADDR_STATUS   ? {13'h0, status} :
              bus.address == ADDR_CONTROL  ? {12'h0, ctrl} :
              bus.address == ADDR_TIME_HM  ? {hh, mm} :
              bus.address == ADDR_TIME_S   ? {8'h00, ss} :
              bus.address == ADDR_ALARM_HM ? alarm_hm : 16'h0000;
  always_ff @(posedge clk)
    if (reset) begin
      presc        <= '0;
      ctrl         <= '0;
      status       <= '0;
      alarm_hm     <= '0;
      bus.readdata <= '0;
    end else begin
      presc        <= time_wr ? '0 : ctrl[CTRL_RUN] && tick ? (presc == PRE_MAX ? '0 : presc + 20'd1) : presc;
      ctrl         <= wr && bus.address == ADDR_CONTROL ? wd[3:0] : ctrl;
      status       <= st_set | (status & ~st_clr);
      alarm_hm     <= ld_al ? wd : alarm_hm;
      bus.readdata <= rd;
    end
  assign irq       = (status[ST_SEC] && ctrl[CTRL_SEC_IRQ_EN]) || (status[ST_ALARM] && ctrl[CTRL_ALARM_IRQ_EN]);
  assign alarm_out = status[ST_ALARM] && ctrl[CTRL_ALARM_EN];
endmodule

// File: tb/tb_clock_alarm_rtc.sv
// tb_clock_alarm_rtc: scoreboard-driven self-checking bench for clock_alarm_rtc with TICKS_PER_SEC=4
module tb_clock_alarm_rtc;
  logic clk = 1'b0;
  logic reset, tick, irq, alarm_out;
  int checks = 0;
  int failures = 0;
  typedef struct {string tag; logic [15:0] exp;} exp_t;
  exp_t sb[$];
  clock_alarm_rtc_if bus();
  clock_alarm_rtc #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .reset(reset), .tick(tick), .bus(bus), .irq(irq), .alarm_out(alarm_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic op(input logic t, input logic w, input logic [2:0] a, input logic [15:0] d);
    tick = t;
    bus.chipselect = w;
    bus.write_n = !w;
    bus.address = a;
    bus.writedata = d;
    @(posedge clk);
    #1;
    tick = 1'b0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
  endtask
  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    op(1'b0, 1'b1, a, d);
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) op(1'b1, 1'b0, 3'd0, 16'h0);
  endtask
  task automatic rd(input logic [2:0] a, input string tag, input logic [15:0] e);
    exp_t x;
    sb.push_back('{tag, e});
    op(1'b0, 1'b0, a, 16'h0);
    if (sb.size() == 0) chk({tag, "_sb_empty"}, 16'd0, 16'd1);
    else begin
      x = sb.pop_front();
      chk(x.tag, bus.readdata, x.exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    tick = 1'b0;
    bus.address = '0;
    bus.chipselect = 1'b0;
    bus.write_n = 1'b1;
    bus.writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_readdata", bus.readdata, 16'h0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_alarm_out", alarm_out, 1'b0);
    for (int i = 0; i < 8; i++) rd(3'(i), $sformatf("rst_addr%0d", i), 16'h0);
    wr(3'd2, 16'h2359);
    wr(3'd3, 16'h0059);
    wr(3'd1, 16'h0001);
    ticks(3);
    rd(3'd3, "pre_roll_s", 16'h0059);
    ticks(1);
    rd(3'd2, "roll_hm", 16'h0000);
    rd(3'd3, "roll_s", 16'h0000);
    rd(3'd0, "roll_status", 16'h0001);
    chk("roll_irq", irq, 1'b0);
    wr(3'd0, 16'h0007);
    wr(3'd4, 16'h0701);
    wr(3'd2, 16'h0700);
    wr(3'd3, 16'h0058);
    wr(3'd1, 16'h000B);
    rd(3'd1, "ctrl_rb", 16'h000B);
    ticks(7);
    chk("alarm_pre_out", alarm_out, 1'b0);
    chk("alarm_pre_irq", irq, 1'b0);
    ticks(1);
    chk("alarm_out", alarm_out, 1'b1);
    chk("alarm_irq", irq, 1'b1);
    rd(3'd0, "alarm_status", 16'h0003);
    rd(3'd2, "alarm_hm_time", 16'h0701);
    wr(3'd0, 16'h0002);
    chk("alarm_clr_out", alarm_out, 1'b0);
    chk("alarm_clr_irq", irq, 1'b0);
    rd(3'd0, "alarm_clr_status", 16'h0001);
    wr(3'd0, 16'h0007);
    wr(3'd2, 16'h2460);
    wr(3'd4, 16'h1A00);
    rd(3'd2, "rej_time_hm", 16'h0701);
    rd(3'd4, "rej_alarm_hm", 16'h0701);
    rd(3'd0, "rej_status", 16'h0004);
    wr(3'd0, 16'h0004);
    rd(3'd0, "err_clr_status", 16'h0000);
    wr(3'd2, 16'h0100);
    ticks(3);
    op(1'b1, 1'b1, 3'd2, 16'h1200);
    rd(3'd2, "coll_hm", 16'h1200);
    rd(3'd3, "coll_s", 16'h0000);
    ticks(3);
    rd(3'd3, "presc_cleared_s", 16'h0000);
    ticks(1);
    rd(3'd3, "post_coll_s", 16'h0001);
    wr(3'd1, 16'h0005);
    chk("sec_irq", irq, 1'b1);
    wr(3'd0, 16'h0007);
    chk("sec_irq_clr", irq, 1'b0);
    ticks(3);
    op(1'b1, 1'b1, 3'd0, 16'h0001);
    chk("w1c_set_irq", irq, 1'b1);
    rd(3'd0, "w1c_set_status", 16'h0001);
    rd(3'd3, "w1c_set_s", 16'h0002);
    wr(3'd1, 16'h0000);
    chk("stop_irq", irq, 1'b0);
    ticks(4);
    rd(3'd3, "stopped_s", 16'h0002);
    wr(3'd1, 16'h0001);
    reset = 1'b1;
    op(1'b1, 1'b1, 3'd3, 16'h0030);
    reset = 1'b0;
    rd(3'd3, "mid_rst_s", 16'h0000);
    rd(3'd2, "mid_rst_hm", 16'h0000);
    rd(3'd1, "mid_rst_ctrl", 16'h0000);
    rd(3'd0, "mid_rst_status", 16'h0000);
    chk("mid_rst_irq", irq, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
